// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the FIFO read-side streaming buffer: occupancy
// state encoding and the delivered-word counter width.
package fifo_rd_pkg;

  localparam int RD_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_state_t;

endpackage

// File: rtl/fifo_rd_stream.sv
// Drains an async-FIFO read port into a valid/ready stream through a 2-entry
// in-order buffer. Optional delivered-word counter rd_cnt under FIFO_RD_CNT_EN.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE = 8
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [DSIZE-1:0]    rdata,
  input  logic                rempty,
  output logic                rinc,
  input  logic                flush,
  output logic                m_valid,
  output logic [DSIZE-1:0]    m_data,
  input  logic                m_ready,
`ifdef FIFO_RD_CNT_EN
  output logic [RD_CNT_W-1:0] rd_cnt,
`endif
  output occ_state_t          dbg_state
);

  // Stream handshake: a word moves to the consumer on every rclk edge where
  // m_valid and m_ready are both 1; m_data is held while m_valid && !m_ready.

  occ_state_t       state;
  logic [DSIZE-1:0] buf_head;
  logic [DSIZE-1:0] buf_tail;
  logic             push;
  logic             pop;

  // rinc depends only on registered occupancy, rempty and flush, never m_ready.
  assign rinc    = rrst_n && !rempty && (state != ST_TWO) && !flush;
  assign push    = rinc;
  assign m_valid = (state != ST_EMPTY) && !flush;
  assign pop     = m_valid && m_ready;
  assign m_data  = buf_head;

  assign dbg_state = state;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state    <= ST_EMPTY;
      buf_head <= '0;
      buf_tail <= '0;
    end else if (flush) begin
      state <= ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (push) begin
            buf_head <= rdata;
            state    <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            buf_head <= rdata;
          end else if (push) begin
            buf_tail <= rdata;
            state    <= ST_TWO;
          end else if (pop) begin
            state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          // Full: no push possible, a pop promotes the tail to the head.
          if (pop) begin
            buf_head <= buf_tail;
            state    <= ST_ONE;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

`ifdef FIFO_RD_CNT_EN
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rd_cnt <= '0;
    end else if (pop) begin
      rd_cnt <= rd_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: queue-based reference model of the
// source FIFO and the in-flight words, directed scenarios then random traffic.
module tb_fifo_rd_stream;
  import fifo_rd_pkg::*;

  localparam int DSIZE = 8;

  logic             rclk = 1'b0;
  logic             rrst_n;
  logic [DSIZE-1:0] rdata;
  logic             rempty;
  logic             rinc;
  logic             flush;
  logic             m_valid;
  logic [DSIZE-1:0] m_data;
  logic             m_ready;
`ifdef FIFO_RD_CNT_EN
  logic [RD_CNT_W-1:0] rd_cnt;
`endif
  occ_state_t       dbg_state;

  // clock / reset
  always #5 rclk = ~rclk;

  fifo_rd_stream #(.DSIZE(DSIZE)) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rdata     (rdata),
    .rempty    (rempty),
    .rinc      (rinc),
    .flush     (flush),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
`ifdef FIFO_RD_CNT_EN
    .rd_cnt    (rd_cnt),
`endif
    .dbg_state (dbg_state)
  );

  logic [DSIZE-1:0] src_q[$];  // words sitting in the source FIFO
  logic [DSIZE-1:0] exp_q[$];  // words popped but not yet delivered, oldest first
  logic [15:0]      cnt_m;
  logic             gap;
  int               vectors;
  int               miscompares;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_src();
    rempty = gap || (src_q.size() == 0);
    rdata  = (src_q.size() == 0) ? '0 : src_q[0];
  endtask

  task automatic add_words(input int n);
    for (int i = 0; i < n; i++) src_q.push_back(DSIZE'($urandom_range(0, 255)));
  endtask

  // One clock: check outputs mid-cycle, then advance the model past the edge.
  task automatic tick();
    logic do_push;
    logic do_pop;
    int   sz;
    drive_src();
    @(negedge rclk);
    sz      = exp_q.size();
    do_push = !rempty && (sz < 2) && !flush;
    do_pop  = (sz > 0) && !flush && m_ready;
    check("rinc", rinc, do_push);
    check("m_valid", m_valid, (sz > 0) && !flush);
    if (sz > 0) check("m_data", m_data, exp_q[0]);
    check("occupancy", dbg_state, sz);
`ifdef FIFO_RD_CNT_EN
    check("rd_cnt", rd_cnt, cnt_m);
`endif
    @(posedge rclk);
    #1;
    if (flush) begin
      exp_q.delete();
    end else begin
      if (do_pop) begin
        void'(exp_q.pop_front());
        cnt_m++;
      end
      if (do_push) exp_q.push_back(src_q.pop_front());
    end
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_rinc"}, rinc, 1'b0);
    check({tag, "_m_valid"}, m_valid, 1'b0);
    check({tag, "_m_data"}, m_data, '0);
    check({tag, "_state"}, dbg_state, ST_EMPTY);
`ifdef FIFO_RD_CNT_EN
    check({tag, "_rd_cnt"}, rd_cnt, '0);
`endif
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cnt_m       = '0;
    gap         = 1'b0;
    flush       = 1'b0;
    m_ready     = 1'b0;
    rrst_n      = 1'b0;

    // reset with a word waiting in the source
    src_q.push_back(8'hA5);
    drive_src();
    #2;
    reset_checks("reset");
    repeat (2) @(posedge rclk);
    src_q.delete();
    drive_src();
    #2 rrst_n = 1'b1;

    // stream of three words, consumer always ready
    src_q.push_back(8'h11);
    src_q.push_back(8'h22);
    src_q.push_back(8'h33);
    m_ready = 1'b1;
    repeat (6) tick();
`ifdef FIFO_RD_CNT_EN
    check("stream_cnt", rd_cnt, 16'd3);
`endif

    // backpressure: only two pops, head held, then drain in order
    add_words(5);
    m_ready = 1'b0;
    repeat (6) tick();
    check("bp_src_left", src_q.size(), 3);
    m_ready = 1'b1;
    repeat (9) tick();

    // source empty every other cycle
    add_words(6);
    for (int i = 0; i < 16; i++) begin
      gap = (i % 2 == 0);
      tick();
    end
    gap = 1'b0;

    // flush while full, then the next popped word comes out first
    add_words(4);
    m_ready = 1'b0;
    repeat (3) tick();
    flush = 1'b1;
    tick();
    flush   = 1'b0;
    m_ready = 1'b1;
    repeat (6) tick();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if (src_q.size() < 4) add_words(3);
      gap     = ($urandom_range(0, 3) == 0);
      m_ready = $urandom_range(0, 1);
      flush   = ($urandom_range(0, 19) == 0);
      tick();
    end
    flush = 1'b0;
    gap   = 1'b0;

    // asynchronous reset in the middle of a transfer
    add_words(4);
    m_ready = 1'b0;
    repeat (3) tick();
    @(posedge rclk);
    #3 rrst_n = 1'b0;
    #1;
    reset_checks("async_reset");
    exp_q.delete();
    cnt_m = '0;
    @(posedge rclk);
    #2 rrst_n = 1'b1;
    m_ready = 1'b1;
    repeat (6) tick();

`ifdef FIFO_RD_CNT_EN
    // counter wrap 65535 -> 0
    while (cnt_m != 16'hffff) begin
      if (src_q.size() < 4) add_words(4);
      tick();
    end
    while (cnt_m == 16'hffff) begin
      if (src_q.size() < 4) add_words(4);
      tick();
    end
    @(negedge rclk);
    check("wrap_rd_cnt", rd_cnt, 16'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
